mem_access_unit: RTL and testbench

//  Parametrised data-memory stage for the pipelined CPU, the successor to the fixed 32-bit word-only stage.

---
 rtl/mem_pkg.sv | 28 ++
 rtl/mem_access_unit_ram_be.sv | 31 +++
 rtl/mem_access_unit.sv | 189 ++++++++++++++++++
 tb/tb_mem_access_unit.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared encodings for the data-memory stage: access sizes, FSM states and
// the byte-lane enable helper used to build RAM write strobes.
package mem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   // Size 2'b11 falls into the default branch and behaves as a full word.
   function automatic logic laneEnable(input logic [1:0] size,
                                       input int unsigned lane,
                                       input int unsigned offset);
      logic en;
      case (size)
         SZ_BYTE: en = (lane == offset);
         SZ_HALF: en = ((lane >> 1) == (offset >> 1));
         default: en = 1'b1;
      endcase
      return en;
   endfunction

endpackage

// File: rtl/mem_access_unit_ram_be.sv
// DEPTH x DATA_W data RAM with per-byte write enables and a registered read
// port; contents are deliberately not reset.
module ram_be #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 1024,
   localparam int BYTES = DATA_W / 8,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              en,
   input  logic [BYTES-1:0]  we,
   input  logic [AW-1:0]     addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   // Read-before-write: a store returns stale data, which the stage discards.
   always_ff @(posedge clk) begin
      if (en) begin
         for (int i = 0; i < BYTES; i++) begin
            if (we[i]) begin
               mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
            end
         end
         rdata <= mem[addr];
      end
   end

endmodule

// File: rtl/mem_access_unit.sv
// Data-memory stage: byte/half/word loads and stores with wait states behind a
// valid/ready handshake. Define MEM_MISALIGN_TRAP_EN to trap misaligned accesses.
module mem_access_unit
   import mem_pkg::*;
#(
   parameter int DATA_W      = 32,
   parameter int DEPTH       = 1024,
   parameter int ADDR_W      = 32,
   parameter int WAIT_STATES = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              misalign,
   output logic              busy
);

   localparam int BYTES = DATA_W / 8;
   localparam int OFFW  = $clog2(BYTES);
   localparam int AW    = $clog2(DEPTH);
   localparam int IDXW  = AW + OFFW;

   state_t state, nextState;
   logic [3:0] cnt, nextCnt;

   logic              weQ, signedQ, misQ;
   logic [1:0]        sizeQ;
   logic [IDXW-1:0]   addrQ;
   logic [DATA_W-1:0] wdataQ;

   logic              idle, accept, doAccess, curMis;
   logic              curWe, curSigned;
   logic [1:0]        curSize;
   logic [IDXW-1:0]   curAddr;
   logic [DATA_W-1:0] curWdata;
   logic [OFFW-1:0]   alignedOff;
   logic [BYTES-1:0]  ramWe;
   logic [DATA_W-1:0] ramWdata, ramRdata, shifted, loadData;
   logic              unusedAddrBits;

   assign unusedAddrBits = ^req_addr[ADDR_W-1:IDXW];

   assign idle      = (state == ST_IDLE);
   assign req_ready = idle;
   assign busy      = !idle;
   assign accept    = req_valid && idle;

   // With zero wait states the access happens on the accept edge, so the
   // live request fields are used while idle and the latched ones afterwards.
   assign curWe     = idle ? req_we                 : weQ;
   assign curSize   = idle ? req_size               : sizeQ;
   assign curSigned = idle ? req_signed             : signedQ;
   assign curAddr   = idle ? req_addr[IDXW-1:0]     : addrQ;
   assign curWdata  = idle ? req_wdata              : wdataQ;

`ifdef MEM_MISALIGN_TRAP_EN
   assign curMis = (curSize == SZ_HALF) ? curAddr[0] :
                   ((curSize != SZ_BYTE) && (curAddr[OFFW-1:0] != '0));
`else
   assign curMis = 1'b0;
`endif

   assign doAccess = !curMis &&
                     ((accept && (WAIT_STATES == 0)) || ((state == ST_WAIT) && (cnt == 4'd0)));

   // Misaligned offsets are rounded down; when trapping, the RAM is not touched anyway.
   always_comb begin
      alignedOff = curAddr[OFFW-1:0];
      case (curSize)
         SZ_BYTE: alignedOff = curAddr[OFFW-1:0];
         SZ_HALF: alignedOff[0] = 1'b0;
         default: alignedOff = '0;
      endcase
   end

   always_comb begin
      ramWe = '0;
      for (int i = 0; i < BYTES; i++) begin
         ramWe[i] = curWe && laneEnable(curSize, i, 32'(alignedOff));
      end
   end

   assign ramWdata = curWdata << {alignedOff, 3'b000};

   ram_be #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) ramInst (
      .clk   (clk),
      .en    (doAccess),
      .we    (ramWe),
      .addr  (curAddr[IDXW-1:OFFW]),
      .wdata (ramWdata),
      .rdata (ramRdata)
   );

   // Lane extraction and extension; fill bits are set first so DATA_W=16 works.
   always_comb begin
      shifted  = ramRdata >> {alignedOff, 3'b000};
      loadData = ramRdata;
      case (curSize)
         SZ_BYTE: begin
            loadData      = {DATA_W{curSigned & shifted[7]}};
            loadData[7:0] = shifted[7:0];
         end
         SZ_HALF: begin
            loadData       = {DATA_W{curSigned & shifted[15]}};
            loadData[15:0] = shifted[15:0];
         end
         default: loadData = ramRdata;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
         cnt   <= 4'd0;
      end else begin
         state <= nextState;
         cnt   <= nextCnt;
      end
   end

   always_comb begin
      nextState = state;
      nextCnt   = cnt;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               if (WAIT_STATES > 0) begin
                  nextState = ST_WAIT;
                  nextCnt   = 4'(WAIT_STATES - 1);
               end else begin
                  nextState = ST_RESP;
               end
            end
         end
         ST_WAIT: begin
            if (cnt == 4'd0) nextState = ST_RESP;
            else             nextCnt   = cnt - 4'd1;
         end
         ST_RESP: nextState = ST_IDLE;
         default: nextState = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         weQ     <= 1'b0;
         sizeQ   <= SZ_BYTE;
         signedQ <= 1'b0;
         addrQ   <= '0;
         wdataQ  <= '0;
         misQ    <= 1'b0;
      end else if (accept) begin
         weQ     <= req_we;
         sizeQ   <= req_size;
         signedQ <= req_signed;
         addrQ   <= req_addr[IDXW-1:0];
         wdataQ  <= req_wdata;
         misQ    <= curMis;
      end
   end

   // The response is registered on the edge leaving RESP, one cycle after the
   // RAM read, so resp_valid and resp_rdata appear together.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         resp_valid <= 1'b0;
         resp_rdata <= '0;
         misalign   <= 1'b0;
      end else begin
         resp_valid <= (state == ST_RESP);
         if (state == ST_RESP) begin
            misalign   <= misQ;
            resp_rdata <= (weQ || misQ) ? '0 : loadData;
         end
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: three instances (1, 3 and 0 wait
// states) checked against a byte-array reference model.
module tb_mem_access_unit;

   localparam int NINST = 3;
   localparam int WS [NINST] = '{0, 1, 3};

   logic        clk = 1'b0;
   logic        rst       [NINST];
   logic        reqValid  [NINST];
   logic        reqReady  [NINST];
   logic        reqWe     [NINST];
   logic [1:0]  reqSize   [NINST];
   logic        reqSigned [NINST];
   logic [31:0] reqAddr   [NINST];
   logic [31:0] reqWdata  [NINST];
   logic        respValid [NINST];
   logic [31:0] respRdata [NINST];
   logic        misal     [NINST];
   logic        busyO     [NINST];

   logic [7:0]  modelMem [NINST][4096];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_access_unit #(.WAIT_STATES(0)) dut0 (
      .clk(clk), .reset(rst[0]), .req_valid(reqValid[0]), .req_ready(reqReady[0]),
      .req_we(reqWe[0]), .req_size(reqSize[0]), .req_signed(reqSigned[0]),
      .req_addr(reqAddr[0]), .req_wdata(reqWdata[0]), .resp_valid(respValid[0]),
      .resp_rdata(respRdata[0]), .misalign(misal[0]), .busy(busyO[0]));

   mem_access_unit #(.WAIT_STATES(1)) dut1 (
      .clk(clk), .reset(rst[1]), .req_valid(reqValid[1]), .req_ready(reqReady[1]),
      .req_we(reqWe[1]), .req_size(reqSize[1]), .req_signed(reqSigned[1]),
      .req_addr(reqAddr[1]), .req_wdata(reqWdata[1]), .resp_valid(respValid[1]),
      .resp_rdata(respRdata[1]), .misalign(misal[1]), .busy(busyO[1]));

   mem_access_unit #(.WAIT_STATES(3)) dut3 (
      .clk(clk), .reset(rst[2]), .req_valid(reqValid[2]), .req_ready(reqReady[2]),
      .req_we(reqWe[2]), .req_size(reqSize[2]), .req_signed(reqSigned[2]),
      .req_addr(reqAddr[2]), .req_wdata(reqWdata[2]), .resp_valid(respValid[2]),
      .resp_rdata(respRdata[2]), .misalign(misal[2]), .busy(busyO[2]));

   // Reference model: memory is a flat byte array, addresses wrap at 4 KiB.
   function automatic void model(input int inst, input logic we, input logic [1:0] size,
                                 input logic sgn, input logic [31:0] addr,
                                 input logic [31:0] wdata,
                                 output logic [31:0] rdata, output logic mis);
      int a, n;
      longint v;
      a = int'(addr % 32'd4096);
      n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
      mis = ((a % n) != 0);
      rdata = 32'd0;
`ifdef MEM_MISALIGN_TRAP_EN
      if (mis) return;
`else
      mis = 1'b0;
      a = a - (a % n);
`endif
      if (we) begin
         for (int i = 0; i < n; i++) modelMem[inst][a+i] = wdata[8*i +: 8];
      end else begin
         v = 0;
         for (int i = 0; i < n; i++) v = v + (longint'(modelMem[inst][a+i]) << (8*i));
         if (sgn && n < 4 && v >= (longint'(1) << (8*n-1))) v = v - (longint'(1) << (8*n));
         rdata = v[31:0];
      end
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One complete access on instance inst, with handshake/latency checks and
   // data compared against the model.
   task automatic applyStimulus(input int inst, input logic we, input logic [1:0] size,
                                input logic sgn, input logic [31:0] addr,
                                input logic [31:0] wdata,
                                output logic [31:0] rd, output logic mi);
      logic [31:0] expD;
      logic        expM;
      int          respK, readyLow;
      model(inst, we, size, sgn, addr, wdata, expD, expM);
      @(negedge clk);
      checkOutput("ready idle", {31'd0, reqReady[inst]}, 32'd1);
      checkOutput("busy idle", {31'd0, busyO[inst]}, 32'd0);
      reqWe[inst] = we; reqSize[inst] = size; reqSigned[inst] = sgn;
      reqAddr[inst] = addr; reqWdata[inst] = wdata; reqValid[inst] = 1'b1;
      respK = -1; readyLow = 0;
      rd = 'x; mi = 1'bx;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk);
         #1;
         if (k == 0) reqValid[inst] = 1'b0;
         if (respValid[inst]) begin
            respK = k;
            rd = respRdata[inst];
            mi = misal[inst];
            break;
         end
         if (!reqReady[inst]) readyLow++;
      end
      checkOutput($sformatf("latency i%0d a%0h", inst, addr), 32'(respK), 32'(WS[inst] + 1));
      checkOutput($sformatf("readyLow i%0d", inst), 32'(readyLow), 32'(WS[inst] + 1));
      checkOutput($sformatf("rdata i%0d we%0d sz%0d a%0h", inst, we, size, addr), rd, expD);
      checkOutput($sformatf("misalign i%0d a%0h", inst, addr), {31'd0, mi}, {31'd0, expM});
      @(posedge clk);
      #1;
      checkOutput("pulse", {31'd0, respValid[inst]}, 32'd0);
   endtask

   initial begin
      logic [31:0] rd, expD;
      logic        mi, expM, sawResp, readyBefore;
      logic [31:0] expQ [$];
      int          issued, got, lastEdge;

      for (int i = 0; i < NINST; i++) begin
         rst[i] = 1'b1; reqValid[i] = 1'b0; reqWe[i] = 1'b0; reqSize[i] = 2'd0;
         reqSigned[i] = 1'b0; reqAddr[i] = 32'd0; reqWdata[i] = 32'd0;
      end
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset ready", {31'd0, reqReady[1]}, 32'd1);
      checkOutput("reset resp_valid", {31'd0, respValid[1]}, 32'd0);
      checkOutput("reset rdata", respRdata[1], 32'd0);
      checkOutput("reset misalign", {31'd0, misal[1]}, 32'd0);
      checkOutput("reset busy", {31'd0, busyO[1]}, 32'd0);
      @(negedge clk);
      for (int i = 0; i < NINST; i++) rst[i] = 1'b0;

      // Directed word/byte/half sequence on the one-wait-state instance
      applyStimulus(1, 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, rd, mi);
      checkOutput("t1 store rdata", rd, 32'd0);
      applyStimulus(1, 1'b0, 2'd2, 1'b0, 32'h10, 32'd0, rd, mi);
      checkOutput("t1 load word", rd, 32'hDEADBEEF);
      applyStimulus(1, 1'b1, 2'd0, 1'b0, 32'h13, 32'h80, rd, mi);
      applyStimulus(1, 1'b0, 2'd2, 1'b0, 32'h10, 32'd0, rd, mi);
      checkOutput("t2 load word", rd, 32'h80ADBEEF);
      applyStimulus(1, 1'b0, 2'd0, 1'b1, 32'h13, 32'd0, rd, mi);
      checkOutput("t2 byte signed", rd, 32'hFFFFFF80);
      applyStimulus(1, 1'b0, 2'd0, 1'b0, 32'h13, 32'd0, rd, mi);
      checkOutput("t2 byte unsigned", rd, 32'h00000080);
      applyStimulus(1, 1'b1, 2'd1, 1'b0, 32'h12, 32'h1234, rd, mi);
      applyStimulus(1, 1'b0, 2'd1, 1'b1, 32'h12, 32'd0, rd, mi);
      checkOutput("t3 half signed", rd, 32'h00001234);
      applyStimulus(1, 1'b0, 2'd2, 1'b0, 32'h1010, 32'd0, rd, mi);
      checkOutput("t3 alias word", rd, 32'h1234BEEF);
      applyStimulus(1, 1'b0, 2'd1, 1'b0, 32'h11, 32'd0, rd, mi);
      applyStimulus(1, 1'b1, 2'd1, 1'b0, 32'h11, 32'h5555, expD, expM);
      applyStimulus(1, 1'b0, 2'd2, 1'b0, 32'h10, 32'd0, expD, expM);
`ifdef MEM_MISALIGN_TRAP_EN
      checkOutput("t4 mis load rdata", rd, 32'd0);
      checkOutput("t4 mis load flag", {31'd0, mi}, 32'd1);
      checkOutput("t4 mis store untouched", expD, 32'h1234BEEF);
`else
      checkOutput("t4 aligned-down rdata", rd, 32'h0000BEEF);
      checkOutput("t4 aligned-down flag", {31'd0, mi}, 32'd0);
      checkOutput("t4 aligned-down store", expD, 32'h12345555);
`endif

      // Randomised traffic over a preloaded 256-byte window, with aliasing upper bits
      for (int a = 0; a < 256; a += 4)
         applyStimulus(1, 1'b1, 2'd2, 1'b0, 32'(a), $urandom, rd, mi);
      for (int t = 0; t < 60; t++)
         applyStimulus(1, 1'(($urandom_range(0, 2)) == 0), 2'($urandom_range(0, 3)),
                       1'($urandom_range(0, 1)),
                       ($urandom & 32'hFFFFF000) | 32'($urandom_range(0, 255)),
                       $urandom, rd, mi);

      // Reset during a pending store on the three-wait-state instance
      applyStimulus(2, 1'b1, 2'd2, 1'b0, 32'h20, 32'h11223344, rd, mi);
      @(negedge clk);
      reqWe[2] = 1'b1; reqSize[2] = 2'd2; reqAddr[2] = 32'h20;
      reqWdata[2] = 32'hA5A5A5A5; reqValid[2] = 1'b1;
      @(posedge clk);
      #1;
      reqValid[2] = 1'b0;
      checkOutput("t5 accepted", {31'd0, reqReady[2]}, 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst[2] = 1'b1;
      sawResp = 1'b0;
      repeat (3) begin
         @(posedge clk);
         #1;
         if (respValid[2]) sawResp = 1'b1;
      end
      @(negedge clk);
      rst[2] = 1'b0;
      checkOutput("t5 ready after reset", {31'd0, reqReady[2]}, 32'd1);
      repeat (6) begin
         @(posedge clk);
         #1;
         if (respValid[2]) sawResp = 1'b1;
      end
      checkOutput("t5 no response", {31'd0, sawResp}, 32'd0);
      applyStimulus(2, 1'b0, 2'd2, 1'b0, 32'h20, 32'd0, rd, mi);
      checkOutput("t5 old value", rd, 32'h11223344);

      // Back-to-back loads with req_valid held high on the zero-wait instance
      for (int a = 32'h40; a < 32'h60; a += 4)
         applyStimulus(0, 1'b1, 2'd2, 1'b0, 32'(a), $urandom, rd, mi);
      issued = 0; got = 0; lastEdge = -1;
      @(negedge clk);
      reqWe[0] = 1'b0; reqSize[0] = 2'($urandom_range(0, 3)); reqSigned[0] = 1'($urandom_range(0, 1));
      reqAddr[0] = 32'h40 + 32'($urandom_range(0, 31)); reqValid[0] = 1'b1;
      for (int e = 0; e < 60 && got < 6; e++) begin
         readyBefore = reqReady[0];
         @(posedge clk);
         #1;
         if (readyBefore && reqValid[0]) begin
            model(0, 1'b0, reqSize[0], reqSigned[0], reqAddr[0], 32'd0, expD, expM);
            expQ.push_back(expD);
            issued++;
            if (issued < 6) begin
               reqSize[0] = 2'($urandom_range(0, 3)); reqSigned[0] = 1'($urandom_range(0, 1));
               reqAddr[0] = 32'h40 + 32'($urandom_range(0, 31));
            end else begin
               reqValid[0] = 1'b0;
            end
         end
         if (respValid[0]) begin
            if (expQ.size() > 0) checkOutput($sformatf("b2b data %0d", got), respRdata[0], expQ.pop_front());
            else checkOutput("b2b unexpected resp", 32'd1, {31'd0, reqValid[0]} & 32'd0);
            if (lastEdge >= 0) checkOutput("b2b spacing", 32'(e - lastEdge), 32'd2);
            lastEdge = e;
            got++;
         end
         @(negedge clk);
      end
      reqValid[0] = 1'b0;
      checkOutput("b2b count", 32'(got), 32'd6);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
